// File: rtl/const_mult_pipe_if.sv
// Handshake and data bundle for const_mult_pipe: upstream valid/ready/data,
// downstream valid/ready/product, overflow flag and pipeline occupancy.
interface const_mult_pipe_if #(
  parameter int DATA_W = 32,
  parameter int STAGES = 4
);
  localparam int CNT_W = $clog2(STAGES + 1);

  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data0;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data0;
  logic              o_ovf;
  logic [CNT_W-1:0]  o_count;

  modport slave (
    input  i_valid, i_data0, i_ready,
    output o_ready, o_valid, o_data0, o_ovf, o_count
  );

  modport master (
    output i_valid, i_data0, i_ready,
    input  o_ready, o_valid, o_data0, o_ovf, o_count
  );
endinterface

// File: rtl/const_mult_pipe.sv
// Pipelined constant-coefficient shift-add multiplier with valid/ready flow control.
// Optional build macro CONST_MULT_PIPE_SATURATE_EN clamps o_data0 to all ones on overflow.
module const_mult_pipe #(
  parameter int                 DATA_W  = 32,
  parameter int                 COEFF_W = 16,
  parameter logic [COEFF_W-1:0] COEFF   = COEFF_W'(24844),
  parameter int                 STAGES  = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  const_mult_pipe_if.slave    bus
);

  localparam int ACC_W = DATA_W + COEFF_W;
  localparam int SL    = (COEFF_W + STAGES - 1) / STAGES;
  localparam int CNT_W = $clog2(STAGES + 1);

  logic              valid_q [STAGES];
  logic [DATA_W-1:0] x_q     [STAGES];
  logic [ACC_W-1:0]  acc_q   [STAGES];
  logic [CNT_W-1:0]  cnt_q;

  logic              v_in    [STAGES];
  logic [DATA_W-1:0] x_in    [STAGES];
  logic [ACC_W-1:0]  acc_base[STAGES];
  logic [ACC_W-1:0]  acc_in  [STAGES];
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] v_nxt;

  // NOTE: every variable in an always_comb gets a value before any condition
  // reads or refines it; a path that leaves one unassigned infers a latch.
  always_comb begin
    v_in[0]     = bus.i_valid;
    x_in[0]     = bus.i_data0;
    acc_base[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k]     = valid_q[k-1];
      x_in[k]     = x_q[k-1];
      acc_base[k] = acc_q[k-1];
    end

    // Each stage adds the shifted operand for the coefficient bits of its slice.
    for (int k = 0; k < STAGES; k++) begin
      acc_in[k] = acc_base[k];
      for (int b = 0; b < COEFF_W; b++) begin
        if ((b / SL) == k && COEFF[b]) begin
          acc_in[k] = acc_in[k] + (ACC_W'(x_in[k]) << b);
        end
      end
    end

    // A stage loads when some stage at or after it is empty, or the output drains;
    // expanding the chain this way keeps it free of self-referencing logic.
    for (int k = 0; k < STAGES; k++) begin
      ld[k] = bus.i_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!valid_q[j]) ld[k] = 1'b1;
      end
      v_nxt[k] = ld[k] ? v_in[k] : valid_q[k];
    end
  end

  // NOTE: the pipeline arrays are reset as well as the valids, so o_data0 and
  // o_ovf read zero during reset rather than stale in-flight products.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        x_q[k]     <= '0;
        acc_q[k]   <= '0;
      end
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples its predecessor's
      // pre-edge value, independent of loop order.
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          valid_q[k] <= v_in[k];
          x_q[k]     <= x_in[k];
          acc_q[k]   <= acc_in[k];
        end
      end
      cnt_q <= CNT_W'($countones(v_nxt));
    end
  end

  logic             ovf;
  logic [ACC_W-1:0] acc_last;

  assign acc_last    = acc_q[STAGES-1];
  assign ovf         = |acc_last[ACC_W-1:DATA_W];
  assign bus.o_ovf   = ovf;
  assign bus.o_valid = valid_q[STAGES-1];
  assign bus.o_ready = ld[0];
  assign bus.o_count = cnt_q;

`ifdef CONST_MULT_PIPE_SATURATE_EN
  assign bus.o_data0 = ovf ? {DATA_W{1'b1}} : acc_last[DATA_W-1:0];
`else
  assign bus.o_data0 = acc_last[DATA_W-1:0];
`endif

endmodule
